// File: rtl/alu_unit_if.sv
// Operand/select/result bundle between the register-file read ports and the ALU.
interface alu_unit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [SEL_WIDTH-1:0]  Sel;
    logic [DATA_WIDTH-1:0] Out;
    logic                  CarryOut;

    // Datapath side: drives operands and function, consumes the registered result.
    modport master (
        output A, B, Sel,
        input  Out, CarryOut
    );

    // ALU side: consumes operands and function, drives the registered result.
    modport slave (
        input  A, B, Sel,
        output Out, CarryOut
    );
endinterface

// File: rtl/alu_unit.sv
// Registered 16-function ALU: result and carry/status flag captured each rising edge.
module alu_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 4
) (
    input  logic     clk,
    input  logic     reset,   // asynchronous, active-low
    alu_unit_if.slave bus
);
    localparam int W = DATA_WIDTH;

    localparam logic [SEL_WIDTH-1:0] OP_ADD  = 4'd0;
    localparam logic [SEL_WIDTH-1:0] OP_SUB  = 4'd1;
    localparam logic [SEL_WIDTH-1:0] OP_MUL  = 4'd2;
    localparam logic [SEL_WIDTH-1:0] OP_DIV  = 4'd3;
    localparam logic [SEL_WIDTH-1:0] OP_SHL  = 4'd4;
    localparam logic [SEL_WIDTH-1:0] OP_SHR  = 4'd5;
    localparam logic [SEL_WIDTH-1:0] OP_ROL  = 4'd6;
    localparam logic [SEL_WIDTH-1:0] OP_ROR  = 4'd7;
    localparam logic [SEL_WIDTH-1:0] OP_AND  = 4'd8;
    localparam logic [SEL_WIDTH-1:0] OP_OR   = 4'd9;
    localparam logic [SEL_WIDTH-1:0] OP_XOR  = 4'd10;
    localparam logic [SEL_WIDTH-1:0] OP_NOR  = 4'd11;
    localparam logic [SEL_WIDTH-1:0] OP_NAND = 4'd12;
    localparam logic [SEL_WIDTH-1:0] OP_XNOR = 4'd13;
    localparam logic [SEL_WIDTH-1:0] OP_GT   = 4'd14;
    localparam logic [SEL_WIDTH-1:0] OP_EQ   = 4'd15;

    logic [W-1:0]   out_d, out_q;
    logic           carry_d, carry_q;
    logic [W:0]     sum;    // extra bit holds the carry out of bit W-1
    logic [W:0]     diff;   // extra bit is set when A < B (borrow)
    logic [2*W-1:0] prod;   // full product; upper half flags overflow

    assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
    assign diff = {1'b0, bus.A} - {1'b0, bus.B};
    assign prod = {{W{1'b0}}, bus.A} * {{W{1'b0}}, bus.B};

    // Next result and flag from the current operands and function select.
    always_comb begin
        // NOTE: both outputs get a default before the case so no path can infer a latch.
        out_d   = '0;
        carry_d = 1'b0;
        case (bus.Sel)
            OP_ADD: begin
                out_d   = sum[W-1:0];
                carry_d = sum[W];
            end
            OP_SUB: begin
                out_d   = diff[W-1:0];
                carry_d = diff[W];
            end
            OP_MUL: begin
                out_d   = prod[W-1:0];
                carry_d = |prod[2*W-1:W];
            end
            OP_DIV: begin
                // Divide by zero saturates to all ones and raises the flag.
                if (bus.B == '0) begin
                    out_d   = '1;
                    carry_d = 1'b1;
                end else begin
                    out_d   = bus.A / bus.B;
                end
            end
            OP_SHL: begin
                out_d   = {bus.A[W-2:0], 1'b0};
                carry_d = bus.A[W-1];
            end
            OP_SHR: begin
                out_d   = {1'b0, bus.A[W-1:1]};
                carry_d = bus.A[0];
            end
            OP_ROL: begin
                out_d   = {bus.A[W-2:0], bus.A[W-1]};
                carry_d = bus.A[W-1];
            end
            OP_ROR: begin
                out_d   = {bus.A[0], bus.A[W-1:1]};
                carry_d = bus.A[0];
            end
            OP_AND:  out_d = bus.A & bus.B;
            OP_OR:   out_d = bus.A | bus.B;
            OP_XOR:  out_d = bus.A ^ bus.B;
            OP_NOR:  out_d = ~(bus.A | bus.B);
            OP_NAND: out_d = ~(bus.A & bus.B);
            OP_XNOR: out_d = ~(bus.A ^ bus.B);
            OP_GT:   out_d = {{(W-1){1'b0}}, (bus.A > bus.B)};
            OP_EQ:   out_d = {{(W-1){1'b0}}, (bus.A == bus.B)};
            default: ;
        endcase
    end

    // Capture result and flag each edge; reset clears both immediately.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign bus.Out      = out_q;
    assign bus.CarryOut = carry_q;
endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit with hand-computed expected values.
module tb_alu_unit;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    alu_unit_if #(.DATA_WIDTH(8), .SEL_WIDTH(4)) bus ();

    alu_unit #(.DATA_WIDTH(8), .SEL_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        bus.A   = a;
        bus.B   = b;
        bus.Sel = sel;
    endtask

    // Wait one edge, then compare result and flag just after it.
    task automatic expect_result(input string tag, input logic [7:0] exp_out, input logic exp_c);
        @(posedge clk);
        #1;
        check({tag, ".out"}, bus.Out, exp_out);
        check({tag, ".c"}, {7'b0, bus.CarryOut}, {7'b0, exp_c});
    endtask

    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] sel, input logic [7:0] exp_out, input logic exp_c);
        apply(a, b, sel);
        expect_result(tag, exp_out, exp_c);
    endtask

    initial begin
        // Reset held low while inputs toggle across several edges.
        reset = 1'b0;
        apply(8'hFF, 8'h01, 4'd0);
        #2;
        check("rst_init.out", bus.Out, 8'h00);
        check("rst_init.c", {7'b0, bus.CarryOut}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            apply(8'($urandom), 8'($urandom), 4'($urandom));
            @(posedge clk);
            #1;
            check("rst_hold.out", bus.Out, 8'h00);
            check("rst_hold.c", {7'b0, bus.CarryOut}, 8'h00);
        end

        // Release between edges; nothing is captured until the next edge.
        @(negedge clk);
        apply(8'd255, 8'd1, 4'd0);
        reset = 1'b1;
        #1;
        check("rst_rel.out", bus.Out, 8'h00);
        expect_result("first_add", 8'd0, 1'b1);

        // Arithmetic, with wrap-around boundaries.
        step("add_plain", 8'd100, 8'd27, 4'd0, 8'd127, 1'b0);
        step("sub_3_5",   8'd3,   8'd5,  4'd1, 8'd254, 1'b1);
        step("sub_0_1",   8'd0,   8'd1,  4'd1, 8'd255, 1'b1);
        step("sub_plain", 8'd10,  8'd3,  4'd1, 8'd7,   1'b0);
        step("mul_16",    8'd16,  8'd16, 4'd2, 8'd0,   1'b1);
        step("mul_255",   8'd255, 8'd255, 4'd2, 8'd1,  1'b1);
        step("mul_plain", 8'd12,  8'd10, 4'd2, 8'd120, 1'b0);
        step("div_200_7", 8'd200, 8'd7,  4'd3, 8'd28,  1'b0);
        step("div_0_0",   8'd0,   8'd0,  4'd3, 8'd255, 1'b1);
        step("div_5_0",   8'd5,   8'd0,  4'd3, 8'd255, 1'b1);

        // Shifts and rotates; B is ignored.
        step("shl_81", 8'h81, 8'hFF, 4'd4, 8'h02, 1'b1);
        step("shr_81", 8'h81, 8'hFF, 4'd5, 8'h40, 1'b1);
        step("rol_81", 8'h81, 8'h00, 4'd6, 8'h03, 1'b1);
        step("ror_81", 8'h81, 8'h00, 4'd7, 8'hC0, 1'b1);
        step("shl_40", 8'h40, 8'hFF, 4'd4, 8'h80, 1'b0);
        step("shr_40", 8'h40, 8'hFF, 4'd5, 8'h20, 1'b0);
        step("rol_40", 8'h40, 8'h5A, 4'd6, 8'h80, 1'b0);
        step("ror_40", 8'h40, 8'h5A, 4'd7, 8'h20, 1'b0);

        // Bitwise logic on F0 / 3C.
        step("and",  8'hF0, 8'h3C, 4'd8,  8'h30, 1'b0);
        step("or",   8'hF0, 8'h3C, 4'd9,  8'hFC, 1'b0);
        step("xor",  8'hF0, 8'h3C, 4'd10, 8'hCC, 1'b0);
        step("nor",  8'hF0, 8'h3C, 4'd11, 8'h03, 1'b0);
        step("nand", 8'hF0, 8'h3C, 4'd12, 8'hCF, 1'b0);
        step("xnor", 8'hF0, 8'h3C, 4'd13, 8'h33, 1'b0);

        // Compares.
        step("gt_5_4", 8'd5, 8'd4, 4'd14, 8'd1, 1'b0);
        step("gt_4_5", 8'd4, 8'd5, 4'd14, 8'd0, 1'b0);
        step("gt_5_5", 8'd5, 8'd5, 4'd14, 8'd0, 1'b0);
        step("eq_9_9", 8'd9, 8'd9, 4'd15, 8'd1, 1'b0);
        step("eq_9_8", 8'd9, 8'd8, 4'd15, 8'd0, 1'b0);

        // Hold: input changes between edges do not reach the outputs.
        apply(8'd255, 8'd255, 4'd2);
        #3;
        check("hold.out", bus.Out, 8'd0);
        expect_result("hold_next", 8'd1, 1'b1);

        // Back-to-back: Sel changes every cycle, each result one edge later.
        step("b2b_add", 8'd7,   8'd9,  4'd0,  8'd16,  1'b0);
        step("b2b_sub", 8'd7,   8'd9,  4'd1,  8'd254, 1'b1);
        step("b2b_mul", 8'd7,   8'd9,  4'd2,  8'd63,  1'b0);
        step("b2b_div", 8'd63,  8'd9,  4'd3,  8'd7,   1'b0);
        step("b2b_xor", 8'hAA,  8'h55, 4'd10, 8'hFF,  1'b0);
        step("b2b_add2", 8'd128, 8'd128, 4'd0, 8'd0,  1'b1);

        // Reset asserted mid-cycle clears outputs at once and drops the in-flight op.
        apply(8'd200, 8'd100, 4'd0);
        @(posedge clk);
        #1;
        check("pre_rst.out", bus.Out, 8'd44);
        check("pre_rst.c", {7'b0, bus.CarryOut}, 8'd1);
        apply(8'd1, 8'd2, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst.out", bus.Out, 8'd0);
        check("mid_rst.c", {7'b0, bus.CarryOut}, 8'd0);
        @(posedge clk);
        #1;
        check("mid_rst_hold.out", bus.Out, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        expect_result("post_rst", 8'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
